// File: rtl/polyphase_pkg.sv
// Shared definitions for the polyphase FIR interpolator.
//   - default parameter values
//   - FSM state encoding
//   - round_sat(): round-half-up shift and saturation of an accumulator
package polyphase_pkg;

  localparam int PHASES_D = 2;
  localparam int TAPS_D   = 16;
  localparam int DW_D     = 16;
  localparam int CW_D     = 16;
  localparam int ACCW_D   = 40;
  localparam int FRAC_D   = 15;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  // Operates on a 64-bit sign-extended accumulator so one function serves
  // any ACCW/DW/FRAC combination; the caller narrows the result to DW bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int dw);
    logic signed [63:0] sh, hi, lo;
    sh = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/polyphase_fir_sequencer_mac.sv
// Registered multiplier followed by an accumulator.
//   clk, reset_n : clock, synchronous active-low reset
//   i_mul_en     : register a new product this cycle
//   i_clr        : clear the accumulator (wins over accumulation)
//   i_a, i_b     : signed sample / coefficient operands
//   o_acc        : signed accumulator, ACCW bits
// A product registered on cycle n is added on cycle n+1; the one-bit
// valid pipe tracks which product register contents are live.
module polyphase_mac
  import polyphase_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int CW   = CW_D,
  parameter int ACCW = ACCW_D
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_mul_en,
  input  logic                   i_clr,
  input  logic signed [DW-1:0]   i_a,
  input  logic signed [CW-1:0]   i_b,
  output logic signed [ACCW-1:0] o_acc
);

  logic signed [DW+CW-1:0] r_prod;
  logic                    r_vld;
  logic signed [ACCW-1:0]  r_acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prod <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_vld <= i_mul_en;
      if (i_mul_en) r_prod <= (DW+CW)'(i_a) * (DW+CW)'(i_b);
      if (i_clr)      r_acc <= '0;
      else if (r_vld) r_acc <= r_acc + ACCW'(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/polyphase_fir_sequencer.sv
// Time-shared polyphase FIR interpolator: each accepted sample yields PHASES
// outputs, each a TAPS-long dot product computed serially on one MAC.
//   clk, reset_n          : clock, synchronous active-low reset
//   data_in/valid_in/ready_in : input sample handshake (accepted only in IDLE)
//   data_out/valid_out/out_ready : output handshake, rounded + saturated
//   phase_out             : phase bank that produced data_out
//   coef_we/coef_phase/coef_tap/coef_wdata : coefficient write port
//   coef_err              : one-cycle pulse when a write is rejected
module polyphase_fir_sequencer
  import polyphase_pkg::*;
#(
  parameter  int PHASES = PHASES_D,
  parameter  int TAPS   = TAPS_D,
  parameter  int DW     = DW_D,
  parameter  int CW     = CW_D,
  parameter  int ACCW   = ACCW_D,
  parameter  int FRAC   = FRAC_D,
  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1,
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic signed [DW-1:0] data_out,
  output logic                 valid_out,
  input  logic                 out_ready,
  output logic [PW-1:0]        phase_out,
  input  logic                 coef_we,
  input  logic [PW-1:0]        coef_phase,
  input  logic [TW-1:0]        coef_tap,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_err
);

  state_t r_state, w_next;

  logic [TW-1:0]        r_wr, r_newest, r_t, w_idx;
  logic [PW-1:0]        r_p;
  logic signed [DW-1:0] r_dline [TAPS];
  logic signed [CW-1:0] r_coef  [PHASES][TAPS];
  logic                 r_coef_err;
  logic signed [ACCW-1:0] w_acc;
  logic w_accept, w_last_phase, w_next_phase, w_coef_ok, w_clr, w_mul_en;

  assign w_accept     = (r_state == IDLE) && valid_in;
  assign w_last_phase = (r_p == PW'(PHASES - 1));
  assign w_next_phase = (r_state == OUT) && out_ready && !w_last_phase;
  // A sample arriving in the same cycle takes priority over a coefficient write.
  assign w_coef_ok    = (r_state == IDLE) && !valid_in;
  assign w_clr        = w_accept || w_next_phase;
  assign w_mul_en     = (r_state == RUN);

  // t=0 is the newest sample; walk backwards through the circular delay line.
  // For non-power-of-two TAPS the TW-bit wrap still lands in [0,TAPS).
  assign w_idx = (r_t <= r_newest) ? (r_newest - r_t)
                                   : (r_newest + TW'(TAPS) - r_t);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (valid_in) w_next = RUN;
      RUN:   if (r_t == TW'(TAPS - 1)) w_next = DRAIN;
      DRAIN: w_next = OUT;
      OUT:   if (out_ready) w_next = w_last_phase ? IDLE : RUN;
      default: w_next = IDLE;
    endcase
  end

  // Outputs; acc is frozen in OUT, so data_out holds under backpressure.
  always_comb begin
    ready_in  = 1'b0;
    valid_out = 1'b0;
    data_out  = '0;
    phase_out = '0;
    case (r_state)
      IDLE: ready_in = 1'b1;
      OUT: begin
        valid_out = 1'b1;
        data_out  = DW'(round_sat(64'(w_acc), FRAC, DW));
        phase_out = r_p;
      end
      default: ;
    endcase
  end

  // Delay line, coefficient file and schedule counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr       <= '0;
      r_newest   <= '0;
      r_t        <= '0;
      r_p        <= '0;
      r_coef_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_dline[i] <= '0;
      for (int ph = 0; ph < PHASES; ph++)
        for (int i = 0; i < TAPS; i++) r_coef[ph][i] <= '0;
    end else begin
      r_coef_err <= coef_we && !w_coef_ok;
      if (coef_we && w_coef_ok) r_coef[coef_phase][coef_tap] <= coef_wdata;
      if (w_accept) begin
        r_dline[r_wr] <= data_in;
        r_newest      <= r_wr;
        r_wr          <= (r_wr == TW'(TAPS - 1)) ? '0 : r_wr + 1'b1;
        r_p           <= '0;
        r_t           <= '0;
      end else if (r_state == RUN) begin
        r_t <= (r_t == TW'(TAPS - 1)) ? '0 : r_t + 1'b1;
      end else if (w_next_phase) begin
        r_p <= r_p + 1'b1;
        r_t <= '0;
      end
    end
  end

  assign coef_err = r_coef_err;

  polyphase_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_mul_en (w_mul_en),
    .i_clr    (w_clr),
    .i_a      (r_dline[w_idx]),
    .i_b      (r_coef[r_p][r_t]),
    .o_acc    (w_acc)
  );

endmodule
